// File: rtl/round_sequencer.sv
// Game-round phase controller: menu/play/death-hold/victory sequencing, restart pulse,
// BCD attempt counter and best (fewest-attempts) record. All state advances on tick only.
module round_sequencer #(
   parameter int unsigned DEATH_HOLD = 24,
   parameter int unsigned WIN_HOLD   = 72
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       start,
   input  logic       death,
   input  logic       win,
   output logic       menu_screen,
   output logic       play_active,
   output logic       death_screen,
   output logic       victory_screen,
   output logic       restart_pulse,
   output logic [7:0] attempts_bcd,
   output logic [7:0] best_bcd,
   output logic       best_valid,
   output logic       attempts_sat
);

   typedef enum logic [1:0] {MENU, PLAY, DEAD, WON} state_t;

   localparam logic [7:0] DEATH_LOAD = 8'(DEATH_HOLD - 1);
   localparam logic [7:0] WIN_LOAD   = 8'(WIN_HOLD - 1);

   state_t     state_q;
   logic [7:0] hold_q;
   logic [7:0] att_q;
   logic [7:0] best_q;
   logic       best_valid_q;
   logic       sat_q;
   logic       restart_q;
   logic       start_s_q, death_s_q, win_s_q;

   logic       start_rise, death_rise, win_rise;
   logic [7:0] att_inc_d;
   logic       best_better;

   assign start_rise = start & ~start_s_q;
   assign death_rise = death & ~death_s_q;
   assign win_rise   = win   & ~win_s_q;

   // Saturating two-digit BCD increment; digits stay within 0-9.
   always_comb begin
      att_inc_d = att_q;
      if (att_q == 8'h99)
         att_inc_d = 8'h99;
      else if (att_q[3:0] == 4'd9)
         att_inc_d = {att_q[7:4] + 4'd1, 4'd0};
      else
         att_inc_d = {att_q[7:4], att_q[3:0] + 4'd1};
   end

   assign best_better = ~best_valid_q
                      | (att_q[7:4] < best_q[7:4])
                      | ((att_q[7:4] == best_q[7:4]) && (att_q[3:0] < best_q[3:0]));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= MENU;
         hold_q       <= 8'd0;
         att_q        <= 8'h00;
         best_q       <= 8'h00;
         best_valid_q <= 1'b0;
         sat_q        <= 1'b0;
         restart_q    <= 1'b0;
         start_s_q    <= 1'b0;
         death_s_q    <= 1'b0;
         win_s_q      <= 1'b0;
      end else begin
         restart_q <= 1'b0;
         if (tick) begin
            start_s_q <= start;
            death_s_q <= death;
            win_s_q   <= win;
            case (state_q)
               MENU: begin
                  if (start_rise) begin
                     state_q   <= PLAY;
                     att_q     <= 8'h01;
                     sat_q     <= 1'b0;
                     restart_q <= 1'b1;
                  end
               end
               PLAY: begin
                  if (death_rise) begin
                     state_q <= DEAD;
                     hold_q  <= DEATH_LOAD;
                  end else if (win_rise) begin
                     state_q <= WON;
                     hold_q  <= WIN_LOAD;
                     if (best_better) begin
                        best_q       <= att_q;
                        best_valid_q <= 1'b1;
                     end
                  end
               end
               DEAD: begin
                  if (hold_q == 8'd0) begin
                     state_q   <= PLAY;
                     att_q     <= att_inc_d;
                     sat_q     <= (att_inc_d == 8'h99);
                     restart_q <= 1'b1;
                  end else begin
                     hold_q <= hold_q - 8'd1;
                  end
               end
               WON: begin
                  // Early start rises are consumed by the edge register and simply lost.
                  if (hold_q == 8'd0) begin
                     if (start_rise) begin
                        state_q <= MENU;
                        att_q   <= 8'h00;
                        sat_q   <= 1'b0;
                     end
                  end else begin
                     hold_q <= hold_q - 8'd1;
                  end
               end
               default: state_q <= MENU;
            endcase
         end
      end
   end

   assign menu_screen    = (state_q == MENU);
   assign play_active    = (state_q == PLAY);
   assign death_screen   = (state_q == DEAD);
   assign victory_screen = (state_q == WON);
   assign restart_pulse  = restart_q;
   assign attempts_bcd   = att_q;
   assign best_bcd       = best_q;
   assign best_valid     = best_valid_q;
   assign attempts_sat   = sat_q;

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Game-round controller sitting between the collision/level logic and the display/obstacle datapath.
- Sequences the menu, play, death-hold and victory phases.
- Issues a one-cycle restart pulse to clear the obstacle position counter, and keeps the two-digit BCD attempt count plus a best (fewest-attempts) record for the seven-segment displays.
- All state advances only on game-tick enables, so phase timing is in game ticks.

Parameters:
- DEATH_HOLD, 24, game ticks the death screen is held before auto-restart (1 s at 24 Hz); legal 1..255.
- WIN_HOLD, 72, minimum game ticks the victory screen is held before start is honoured; legal 1..255.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- reset  input  1  asynchronous, active-high; clears all state.
- tick  input  1  one-clk-wide game-tick enable; all sampling and transitions occur only on clk edges with tick=1.
- start  input  1  player jump/start button, active-high level.
- death  input  1  collision indication, level; may stay high for many ticks.
- win  input  1  end-of-level indication, level.
- menu_screen  output  1  high in MENU.
- play_active  output  1  high in PLAY.
- death_screen  output  1  high in DEAD.
- victory_screen  output  1  high in WON.
- restart_pulse  output  1  one clk wide; clears obstacle counter and player position.
- attempts_bcd  output  8  [7:4] tens digit, [3:0] ones digit.
- best_bcd  output  8  fewest attempts of any completed round; 8'h00 when best_valid=0.
- best_valid  output  1  at least one victory since reset.
- attempts_sat  output  1  attempt count saturated at 99.

Behaviour:
- Reset (asynchronous):
  - State = MENU; hold counter = 0.
  - attempts_bcd = 8'h00, best_bcd = 8'h00.
  - best_valid, attempts_sat and restart_pulse = 0; all internal edge-detect registers = 0.
- Edge detection: start, death and win are sampled into registers on tick cycles only. A rise is defined as sampled now = 1 and sampled on the previous tick = 0. A level held high produces exactly one event.
- All outputs are registered and update on the same clk edge that evaluates the tick.
- restart_pulse is high for exactly one clk cycle, the cycle following that edge, and is never held longer even if tick stays high.
- MENU:
  - start rise -> PLAY; attempts_bcd = 8'h01; attempts_sat = 0; restart_pulse fires.
  - death and win are ignored.
- PLAY:
  - death rise -> DEAD; hold counter loaded with DEATH_HOLD-1.
  - win rise with no death rise -> WON; hold counter loaded with WIN_HOLD-1; best update performed on this edge.
  - Simultaneous death rise and win rise: death has priority -> DEAD.
- DEAD:
  - Hold counter decrements on each tick.
  - On the tick where the counter is 0 -> PLAY; attempts incremented; restart_pulse fires.
  - start, win and death are ignored.
  - Dwell time is exactly DEATH_HOLD ticks.
- WON:
  - Hold counter decrements on each tick until it reaches 0, then stays at 0.
  - start rise is honoured only when the counter is already 0 at that tick -> MENU; attempts_bcd = 8'h00; attempts_sat = 0.
  - A start rise before expiry is consumed and discarded; a new rise is required after expiry.
- Attempt increment:
  - BCD: ones 9 -> 0 with tens +1.
  - At 8'h99 the count holds at 8'h99 and attempts_sat = 1.
  - Digits never take values A-F.
- Best update on PLAY->WON: if best_valid = 0, or attempts_bcd < best_bcd (BCD compare: tens first, then ones), then best_bcd = attempts_bcd and best_valid = 1. Equal counts leave best unchanged.
- tick = 0: no state, counter, edge-register or output change, except that restart_pulse self-clears.
- Reset asserted mid-hold or mid-round aborts immediately to the reset values. best is not preserved across reset.

Test Plan:
- Apply reset, then tick every 4 clks, pulse start -> menu_screen=1 until the start-rise tick; next clk play_active=1, attempts_bcd=8'h01, one-clk restart_pulse.
- In PLAY, hold death high 40 ticks, DEATH_HOLD=24 -> death_screen high for exactly 24 ticks, then PLAY, attempts_bcd=8'h02, single restart_pulse; the still-high death causes no second DEAD until it falls and rises again.
- Drive 98 further deaths from attempts 8'h02 -> sequence passes 8'h09 -> 8'h10; reaches 8'h99 with attempts_sat=1; the next death keeps 8'h99.
- Win with 8'h05 -> victory_screen=1, best_bcd=8'h05, best_valid=1. Start pressed at tick 10 of the hold -> ignored. Start rise after 72 ticks -> MENU, attempts 8'h00. Next round won at 8'h07 -> best stays 8'h05; round won at 8'h03 -> best 8'h03.
- death and win rise on the same tick in PLAY -> DEAD, best unchanged.
- Assert reset mid-DEAD and mid-WON -> all outputs at reset values asynchronously (before the next clk edge), best_valid=0.
